load_miss_handler: RTL and testbench

LOAD_MISS_HANDLER -- requirements
Module: load_miss_handler

---
 rtl/sys_defs.sv | 35 +++
 rtl/mshr_pri_enc.sv | 25 ++
 rtl/load_miss_handler.sv | 148 ++++++++++++++
 tb/tb_load_miss_handler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the load miss handler: MSHR depth, memory bus command encoding
// and the MSHR row layout used by every entry.
package sys_defs;

  localparam int MSHR_SIZE = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND_T;

  typedef enum logic [1:0] {
    MSHR_EMPTY      = 2'h0,
    MSHR_WAIT_ISSUE = 2'h1,
    MSHR_WAIT_DATA  = 2'h2
  } MSHR_STATE_T;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [3:0]  tag;
    MSHR_STATE_T state;
  } MSHR_ROW_T;

  function automatic MSHR_ROW_T mshr_row_empty();
    MSHR_ROW_T row;
    row.valid = 1'b0;
    row.addr  = '0;
    row.tag   = '0;
    row.state = MSHR_EMPTY;
    return row;
  endfunction

endpackage

// File: rtl/mshr_pri_enc.sv
// Lowest-index priority encoder: combinational, zero latency, no backpressure.
// idx_o is 0 and vld_o low when no request bit is set.
module mshr_pri_enc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         req_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     vld_o
);

  localparam int IDX_W = $clog2(WIDTH);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_miss_handler.sv
// Load MSHR: merges duplicate misses, issues one load per cycle, broadcasts fills to the load queue
// one cycle after the tag match; miss_req_ready is low only when no entry is empty and no address matches.
module load_miss_handler #(
  parameter int MSHR_SIZE = sys_defs::MSHR_SIZE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        miss_req_valid,
  input  logic [63:0] miss_req_addr,
  output logic        miss_req_ready,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data,
  output logic        lq_miss_valid,
  output logic [63:0] lq_miss_addr,
  output logic [63:0] lq_miss_data
);

  import sys_defs::MSHR_ROW_T;
  import sys_defs::MSHR_EMPTY;
  import sys_defs::MSHR_WAIT_ISSUE;
  import sys_defs::MSHR_WAIT_DATA;
  import sys_defs::BUS_LOAD;
  import sys_defs::BUS_NONE;
  import sys_defs::mshr_row_empty;

  localparam int IDX_W = $clog2(MSHR_SIZE);

  MSHR_ROW_T mshr_q [MSHR_SIZE];
  MSHR_ROW_T mshr_d [MSHR_SIZE];

  logic        lq_vld_q,  lq_vld_d;
  logic [63:0] lq_addr_q, lq_addr_d;
  logic [63:0] lq_data_q, lq_data_d;

  logic [MSHR_SIZE-1:0] empty_vec;
  logic [MSHR_SIZE-1:0] issue_vec;
  logic                 merge_hit;
  logic                 fill_hit;
  logic [IDX_W-1:0]     fill_idx;

  logic [IDX_W-1:0]     alloc_idx;
  logic                 alloc_vld;
  logic [IDX_W-1:0]     issue_idx;
  logic                 issue_vld;

  logic                 alloc_fire;
  logic                 issue_grant;

  // Per-entry status vectors, address match for merging, and the tag match for fills.
  always_comb begin
    empty_vec = '0;
    issue_vec = '0;
    merge_hit = 1'b0;
    fill_hit  = 1'b0;
    fill_idx  = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      empty_vec[i] = (mshr_q[i].state == MSHR_EMPTY);
      issue_vec[i] = (mshr_q[i].state == MSHR_WAIT_ISSUE);
      if ((mshr_q[i].state != MSHR_EMPTY) && (mshr_q[i].addr == miss_req_addr)) begin
        merge_hit = 1'b1;
      end
      if (!fill_hit && (mem2proc_tag != 4'd0) &&
          (mshr_q[i].state == MSHR_WAIT_DATA) && (mshr_q[i].tag == mem2proc_tag)) begin
        fill_hit = 1'b1;
        fill_idx = IDX_W'(i);
      end
    end
  end

  mshr_pri_enc #(
    .WIDTH (MSHR_SIZE)
  ) u_alloc_enc (
    .req_i (empty_vec),
    .idx_o (alloc_idx),
    .vld_o (alloc_vld)
  );

  mshr_pri_enc #(
    .WIDTH (MSHR_SIZE)
  ) u_issue_enc (
    .req_i (issue_vec),
    .idx_o (issue_idx),
    .vld_o (issue_vld)
  );

  // Empty-ness comes from registered state, so an entry freed this cycle is only reusable next cycle.
  assign miss_req_ready   = alloc_vld | merge_hit;
  assign alloc_fire       = miss_req_valid & alloc_vld & ~merge_hit;
  assign issue_grant      = issue_vld & (mem2proc_response != 4'd0);

  assign proc2mem_command = issue_vld ? BUS_LOAD : BUS_NONE;
  assign proc2mem_addr    = issue_vld ? mshr_q[issue_idx].addr : 64'd0;

  assign lq_miss_valid    = lq_vld_q;
  assign lq_miss_addr     = lq_addr_q;
  assign lq_miss_data     = lq_data_q;

  // Allocation, issue and fill always target entries in different states, so they never collide.
  always_comb begin
    for (int i = 0; i < MSHR_SIZE; i++) begin
      mshr_d[i] = mshr_q[i];
    end
    lq_vld_d  = fill_hit;
    lq_addr_d = lq_addr_q;
    lq_data_d = lq_data_q;

    if (issue_grant) begin
      mshr_d[issue_idx].tag   = mem2proc_response;
      mshr_d[issue_idx].state = MSHR_WAIT_DATA;
    end

    if (fill_hit) begin
      lq_addr_d              = mshr_q[fill_idx].addr;
      lq_data_d              = mem2proc_data;
      mshr_d[fill_idx].valid = 1'b0;
      mshr_d[fill_idx].state = MSHR_EMPTY;
    end

    if (alloc_fire) begin
      mshr_d[alloc_idx].valid = 1'b1;
      mshr_d[alloc_idx].addr  = miss_req_addr;
      mshr_d[alloc_idx].tag   = 4'd0;
      mshr_d[alloc_idx].state = MSHR_WAIT_ISSUE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        mshr_q[i] <= mshr_row_empty();
      end
      lq_vld_q  <= 1'b0;
      lq_addr_q <= 64'd0;
      lq_data_q <= 64'd0;
    end else begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        mshr_q[i] <= mshr_d[i];
      end
      lq_vld_q  <= lq_vld_d;
      lq_addr_q <= lq_addr_d;
      lq_data_q <= lq_data_d;
    end
  end

endmodule

// File: tb/tb_load_miss_handler.sv
// Testbench for load_miss_handler: directed scenarios plus a randomized run against a slot-based reference model.
module tb_load_miss_handler;
  import sys_defs::*;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        miss_req_valid;
  logic [63:0] miss_req_addr;
  logic        miss_req_ready;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        lq_miss_valid;
  logic [63:0] lq_miss_addr;
  logic [63:0] lq_miss_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: each slot is either free or holds a miss address, optionally with a memory tag.
  logic [63:0] s_addr   [N];
  bit          s_busy   [N];
  bit          s_tagged [N];
  logic [3:0]  s_tag    [N];
  logic        e_lq_v;
  logic [63:0] e_lq_a;
  logic [63:0] e_lq_d;

  always #5 clock = ~clock;

  load_miss_handler #(.MSHR_SIZE(N)) dut (
    .clock             (clock),
    .reset             (reset),
    .miss_req_valid    (miss_req_valid),
    .miss_req_addr     (miss_req_addr),
    .miss_req_ready    (miss_req_ready),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_tag      (mem2proc_tag),
    .mem2proc_data     (mem2proc_data),
    .lq_miss_valid     (lq_miss_valid),
    .lq_miss_addr      (lq_miss_addr),
    .lq_miss_data      (lq_miss_data)
  );

  function automatic bit m_ready(input logic [63:0] a);
    for (int i = 0; i < N; i++) begin
      if (!s_busy[i]) return 1'b1;
      if (s_addr[i] == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_issue();
    for (int i = 0; i < N; i++) begin
      if (s_busy[i] && !s_tagged[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] free_tag();
    logic [3:0] t;
    bit used;
    for (int k = 0; k < 80; k++) begin
      if (k < 64) t = 4'(1 + $urandom_range(14));
      else        t = 4'(k - 64);
      used = (t == 4'd0);
      for (int i = 0; i < N; i++) begin
        if (s_busy[i] && s_tagged[i] && s_tag[i] == t) used = 1'b1;
      end
      if (!used) return t;
    end
    return 4'd15;
  endfunction

  task automatic drive(input logic v, input logic [63:0] a, input logic [3:0] resp,
                       input logic [3:0] tg, input logic [63:0] d);
    miss_req_valid    = v;
    miss_req_addr     = a;
    mem2proc_response = resp;
    mem2proc_tag      = tg;
    mem2proc_data     = d;
    #1;
  endtask

  // Advance one clock edge, updating the model from the inputs present before the edge.
  task automatic tick();
    int fi;
    int ii;
    int ai;
    bit merge;
    bit acc;
    fi = -1;
    ai = -1;
    merge = 1'b0;
    if (mem2proc_tag != 4'd0) begin
      for (int i = 0; i < N; i++) begin
        if (fi < 0 && s_busy[i] && s_tagged[i] && s_tag[i] == mem2proc_tag) fi = i;
      end
    end
    ii = m_issue();
    for (int i = 0; i < N; i++) begin
      if (s_busy[i] && s_addr[i] == miss_req_addr) merge = 1'b1;
      if (ai < 0 && !s_busy[i]) ai = i;
    end
    acc = miss_req_valid && (merge || ai >= 0);
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        s_busy[i] = 1'b0; s_tagged[i] = 1'b0; s_addr[i] = '0; s_tag[i] = '0;
      end
      e_lq_v = 1'b0; e_lq_a = '0; e_lq_d = '0;
    end else begin
      e_lq_v = (fi >= 0);
      if (fi >= 0) begin
        e_lq_a = s_addr[fi];
        e_lq_d = mem2proc_data;
        s_busy[fi] = 1'b0;
        s_tagged[fi] = 1'b0;
      end
      if (ii >= 0 && mem2proc_response != 4'd0) begin
        s_tagged[ii] = 1'b1;
        s_tag[ii] = mem2proc_response;
      end
      if (acc && !merge) begin
        s_busy[ai] = 1'b1;
        s_tagged[ai] = 1'b0;
        s_addr[ai] = miss_req_addr;
      end
    end
    @(negedge clock);
  endtask

  // Allocate four addresses base, base+0x40, ... and tag them t0..t0+3 in order.
  task automatic fill_four(input logic [63:0] base, input logic [3:0] t0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, base + 64'(i * 64), (i == 0) ? 4'd0 : 4'(t0 + 4'(i - 1)), 4'd0, 64'd0);
      tick();
    end
    drive(1'b0, 64'd0, 4'(t0 + 4'd3), 4'd0, 64'd0);
    tick();
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    checks++; if (lq_miss_valid !== 1'b0) begin failures++; $display("FAIL rst_lq_valid got=%0b exp=0", lq_miss_valid); end
    checks++; if (lq_miss_addr !== 64'd0) begin failures++; $display("FAIL rst_lq_addr got=%h exp=0", lq_miss_addr); end
    checks++; if (lq_miss_data !== 64'd0) begin failures++; $display("FAIL rst_lq_data got=%h exp=0", lq_miss_data); end
    checks++; if (proc2mem_command !== BUS_NONE) begin failures++; $display("FAIL rst_cmd got=%0d exp=%0d", proc2mem_command, BUS_NONE); end
    checks++; if (proc2mem_addr !== 64'd0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", proc2mem_addr); end
    checks++; if (miss_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", miss_req_ready); end
  endtask

  task automatic test_basic_fill();
    drive(1'b1, 64'h100, 4'd0, 4'd0, 64'd0);
    checks++; if (miss_req_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", miss_req_ready); end
    checks++; if (proc2mem_command !== BUS_NONE) begin failures++; $display("FAIL basic_cmd_alloc got=%0d exp=%0d", proc2mem_command, BUS_NONE); end
    tick();
    drive(1'b0, 64'd0, 4'd3, 4'd0, 64'd0);
    checks++; if (proc2mem_command !== BUS_LOAD) begin failures++; $display("FAIL basic_cmd_issue got=%0d exp=%0d", proc2mem_command, BUS_LOAD); end
    checks++; if (proc2mem_addr !== 64'h100) begin failures++; $display("FAIL basic_issue_addr got=%h exp=100", proc2mem_addr); end
    tick();
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
      checks++; if (proc2mem_command !== BUS_NONE || lq_miss_valid !== 1'b0) begin
        failures++; $display("FAIL basic_idle k=%0d cmd=%0d lq_valid=%0b exp cmd=0 lq_valid=0", k, proc2mem_command, lq_miss_valid);
      end
      tick();
    end
    drive(1'b0, 64'd0, 4'd0, 4'd3, 64'hDEAD);
    tick();
    checks++; if (lq_miss_valid !== 1'b1) begin failures++; $display("FAIL basic_fill_valid got=%0b exp=1", lq_miss_valid); end
    checks++; if (lq_miss_addr !== 64'h100) begin failures++; $display("FAIL basic_fill_addr got=%h exp=100", lq_miss_addr); end
    checks++; if (lq_miss_data !== 64'hDEAD) begin failures++; $display("FAIL basic_fill_data got=%h exp=dead", lq_miss_data); end
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
    checks++; if (lq_miss_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%0b exp=0", lq_miss_valid); end
    checks++; if (lq_miss_addr !== 64'h100 || lq_miss_data !== 64'hDEAD) begin
      failures++; $display("FAIL basic_hold addr=%h data=%h exp addr=100 data=dead", lq_miss_addr, lq_miss_data);
    end
  endtask

  task automatic test_reissue();
    drive(1'b1, 64'h200, 4'd0, 4'd0, 64'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 64'd0, (k == 3) ? 4'd5 : 4'd0, 4'd0, 64'd0);
      checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h200) begin
        failures++; $display("FAIL reissue k=%0d cmd=%0d addr=%h exp cmd=%0d addr=200", k, proc2mem_command, proc2mem_addr, BUS_LOAD);
      end
      tick();
    end
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    checks++; if (proc2mem_command !== BUS_NONE || proc2mem_addr !== 64'd0) begin
      failures++; $display("FAIL reissue_done cmd=%0d addr=%h exp cmd=0 addr=0", proc2mem_command, proc2mem_addr);
    end
    tick();
    drive(1'b0, 64'd0, 4'd0, 4'd5, 64'h5555_0000_AAAA_1111);
    tick();
    checks++; if (lq_miss_valid !== 1'b1 || lq_miss_addr !== 64'h200 || lq_miss_data !== 64'h5555_0000_AAAA_1111) begin
      failures++; $display("FAIL reissue_fill valid=%0b addr=%h data=%h exp 1/200/5555_0000_aaaa_1111", lq_miss_valid, lq_miss_addr, lq_miss_data);
    end
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
  endtask

  task automatic test_full_merge();
    fill_four(64'h100, 4'd1);
    drive(1'b1, 64'h300, 4'd0, 4'd0, 64'd0);
    checks++; if (miss_req_ready !== 1'b0) begin failures++; $display("FAIL full_ready_new got=%0b exp=0", miss_req_ready); end
    tick();
    drive(1'b1, 64'h100, 4'd0, 4'd0, 64'd0);
    checks++; if (miss_req_ready !== 1'b1) begin failures++; $display("FAIL full_ready_merge got=%0b exp=1", miss_req_ready); end
    tick();
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    checks++; if (proc2mem_command !== BUS_NONE) begin failures++; $display("FAIL merge_no_issue got=%0d exp=0", proc2mem_command); end
    checks++; if (miss_req_ready !== 1'b0) begin failures++; $display("FAIL merge_no_alloc got=%0b exp=0", miss_req_ready); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 64'd0, 4'd0, 4'(k + 1), 64'hA000 + 64'(k));
      tick();
      checks++; if (lq_miss_valid !== 1'b1 || lq_miss_addr !== 64'h100 + 64'(k * 64) || lq_miss_data !== 64'hA000 + 64'(k)) begin
        failures++; $display("FAIL drain k=%0d valid=%0b addr=%h data=%h exp 1/%h/%h", k, lq_miss_valid, lq_miss_addr, lq_miss_data, 64'h100 + 64'(k * 64), 64'hA000 + 64'(k));
      end
    end
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
  endtask

  task automatic test_out_of_order();
    drive(1'b1, 64'h400, 4'd0, 4'd0, 64'd0);
    tick();
    drive(1'b1, 64'h440, 4'd1, 4'd0, 64'd0);
    checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h400) begin
      failures++; $display("FAIL ooo_issue0 cmd=%0d addr=%h exp 1/400", proc2mem_command, proc2mem_addr);
    end
    tick();
    drive(1'b0, 64'd0, 4'd2, 4'd0, 64'd0);
    checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h440) begin
      failures++; $display("FAIL ooo_issue1 cmd=%0d addr=%h exp 1/440", proc2mem_command, proc2mem_addr);
    end
    tick();
    drive(1'b0, 64'd0, 4'd0, 4'd2, 64'hBEEF0002);
    tick();
    checks++; if (lq_miss_valid !== 1'b1 || lq_miss_addr !== 64'h440 || lq_miss_data !== 64'hBEEF0002) begin
      failures++; $display("FAIL ooo_tag2 valid=%0b addr=%h data=%h exp 1/440/beef0002", lq_miss_valid, lq_miss_addr, lq_miss_data);
    end
    drive(1'b0, 64'd0, 4'd0, 4'd1, 64'hBEEF0001);
    tick();
    checks++; if (lq_miss_valid !== 1'b1 || lq_miss_addr !== 64'h400 || lq_miss_data !== 64'hBEEF0001) begin
      failures++; $display("FAIL ooo_tag1 valid=%0b addr=%h data=%h exp 1/400/beef0001", lq_miss_valid, lq_miss_addr, lq_miss_data);
    end
    drive(1'b0, 64'd0, 4'd0, 4'd7, 64'h777);
    tick();
    checks++; if (lq_miss_valid !== 1'b0 || lq_miss_addr !== 64'h400 || lq_miss_data !== 64'hBEEF0001) begin
      failures++; $display("FAIL ooo_unknown valid=%0b addr=%h data=%h exp 0/400/beef0001", lq_miss_valid, lq_miss_addr, lq_miss_data);
    end
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
  endtask

  task automatic test_full_same_cycle_and_reset();
    fill_four(64'h800, 4'd1);
    drive(1'b1, 64'h900, 4'd0, 4'd2, 64'hF00D);
    checks++; if (miss_req_ready !== 1'b0) begin failures++; $display("FAIL samecyc_ready got=%0b exp=0", miss_req_ready); end
    tick();
    checks++; if (lq_miss_valid !== 1'b1 || lq_miss_addr !== 64'h840 || lq_miss_data !== 64'hF00D) begin
      failures++; $display("FAIL samecyc_fill valid=%0b addr=%h data=%h exp 1/840/f00d", lq_miss_valid, lq_miss_addr, lq_miss_data);
    end
    drive(1'b1, 64'h900, 4'd0, 4'd0, 64'd0);
    checks++; if (miss_req_ready !== 1'b1) begin failures++; $display("FAIL nextcyc_ready got=%0b exp=1", miss_req_ready); end
    tick();
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h900) begin
      failures++; $display("FAIL realloc_issue cmd=%0d addr=%h exp 1/900", proc2mem_command, proc2mem_addr);
    end
    tick();
    reset = 1'b1;
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    checks++; if (proc2mem_command !== BUS_NONE || miss_req_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_state cmd=%0d ready=%0b exp 0/1", proc2mem_command, miss_req_ready);
    end
    checks++; if (lq_miss_valid !== 1'b0 || lq_miss_addr !== 64'd0) begin
      failures++; $display("FAIL midrst_lq valid=%0b addr=%h exp 0/0", lq_miss_valid, lq_miss_addr);
    end
    drive(1'b0, 64'd0, 4'd0, 4'd1, 64'h1234);
    tick();
    checks++; if (lq_miss_valid !== 1'b0 || lq_miss_data !== 64'd0) begin
      failures++; $display("FAIL stale_tag valid=%0b data=%h exp 0/0", lq_miss_valid, lq_miss_data);
    end
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
  endtask

  task automatic test_random();
    logic        v;
    logic [63:0] a;
    logic [3:0]  resp;
    logic [3:0]  tg;
    logic [63:0] d;
    int          ii;
    int          r;
    int          q[$];
    logic [1:0]  exp_cmd;
    logic [63:0] exp_addr;
    reset = 1'b1;
    drive(1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      v    = 1'($urandom_range(1));
      a    = 64'h1000 + 64'($urandom_range(5)) * 64'd8;
      resp = 4'd0;
      if (m_issue() >= 0 && $urandom_range(2) != 0) resp = free_tag();
      tg = 4'd0;
      r  = $urandom_range(3);
      q.delete();
      for (int i = 0; i < N; i++) if (s_busy[i] && s_tagged[i]) q.push_back(i);
      if (r < 2 && q.size() > 0) tg = s_tag[q[$urandom_range(q.size() - 1)]];
      else if (r == 2)           tg = free_tag();
      d = {32'($urandom), 32'($urandom)};
      drive(v, a, resp, tg, d);
      ii       = m_issue();
      exp_cmd  = (ii >= 0) ? BUS_LOAD : BUS_NONE;
      exp_addr = (ii >= 0) ? s_addr[ii] : 64'd0;
      checks++; if (miss_req_ready !== m_ready(a)) begin
        failures++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, miss_req_ready, m_ready(a));
      end
      checks++; if (proc2mem_command !== exp_cmd || proc2mem_addr !== exp_addr) begin
        failures++; $display("FAIL rnd_issue n=%0d cmd=%0d addr=%h exp %0d/%h", n, proc2mem_command, proc2mem_addr, exp_cmd, exp_addr);
      end
      tick();
      checks++; if (lq_miss_valid !== e_lq_v || lq_miss_addr !== e_lq_a || lq_miss_data !== e_lq_d) begin
        failures++; $display("FAIL rnd_fill n=%0d got %0b/%h/%h exp %0b/%h/%h", n, lq_miss_valid, lq_miss_addr, lq_miss_data, e_lq_v, e_lq_a, e_lq_d);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      s_busy[i] = 1'b0; s_tagged[i] = 1'b0; s_addr[i] = '0; s_tag[i] = '0;
    end
    e_lq_v = 1'b0; e_lq_a = '0; e_lq_d = '0;
    test_reset();
    test_basic_fill();
    test_reissue();
    test_full_merge();
    test_out_of_order();
    test_full_same_cycle_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
